// File: rtl/input_buf_pkg.sv
// Shared definitions for the input-memory ping-pong scheduler.
//   bank_state_t : lifecycle of one input-memory bank
//   NUM_BANKS    : number of banks being ping-ponged
//   ACCUM_ROW    : largest legal tile row count for the default geometry
//   bank_onehot  : converts a bank pointer into a start-pulse vector
package input_buf_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    LOADING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  localparam int NUM_BANKS      = 2;
  localparam int DEF_SYS_ROW    = 16;
  localparam int DEF_SYS_COL    = 16;
  localparam int DEF_ACCUM_SIZE = 4096;
  localparam int ACCUM_ROW      = DEF_ACCUM_SIZE / DEF_SYS_COL;

  function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic bank);
    return bank ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/input_buf_bank_fsm.sv
// Lifecycle tracker for a single input-memory bank.
//   clk, rstn     : clock, asynchronous active-low reset
//   load          : legal command accepted for this bank (only honoured when EMPTY)
//   load_num_row  : row count of the accepted command
//   wr_done       : write-done level from the bank controller
//   rd_issue      : read start issued for this bank (only honoured when FULL)
//   rd_done       : read-complete pulse from the array side
//   state         : current bank state
//   nrow          : row count of the tile held in this bank
//   drain_done    : rd_done arrived while DRAINING (tile completed)
module input_buf_bank_fsm
  import input_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_num_row,
  input  logic                  wr_done,
  input  logic                  rd_issue,
  input  logic                  rd_done,
  output bank_state_t           state,
  output logic [DATA_WIDTH-1:0] nrow,
  output logic                  drain_done
);

  bank_state_t           state_reg;
  bank_state_t           state_next;
  logic                  wr_done_q_reg;
  logic                  wr_done_rise;
  logic [DATA_WIDTH-1:0] nrow_reg;

  // wr_done is a level that stays high until the controller sees the next
  // write start, so only its rising edge marks the end of a load.
  assign wr_done_rise = wr_done && !wr_done_q_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= EMPTY;
      wr_done_q_reg <= 1'b0;
      nrow_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      wr_done_q_reg <= wr_done;
      if (load && (state_reg == EMPTY)) begin
        nrow_reg <= load_num_row;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY:    if (load)         state_next = LOADING;
      LOADING:  if (wr_done_rise) state_next = FULL;
      FULL:     if (rd_issue)     state_next = DRAINING;
      DRAINING: if (rd_done)      state_next = EMPTY;
      default:                    state_next = EMPTY;
    endcase
  end

  always_comb begin
    state      = state_reg;
    nrow       = nrow_reg;
    // A read-complete for a bank that is not draining is stale and ignored.
    drain_done = rd_done && (state_reg == DRAINING);
  end

endmodule

// File: rtl/input_buf_sched.sv
// Ping-pong scheduler for the two input-memory banks feeding the systolic
// array: tile k+1 is written into one bank while tile k streams out of the
// other, and tiles always drain in the order they were accepted.
//   clk, rstn    : clock, asynchronous active-low reset
//   cmd_valid    : tile-load command valid
//   cmd_ready    : scheduler can accept a command this cycle
//   cmd_num_row  : rows in the tile (legal range 1..ACCUM_SIZE/SYS_COL)
//   wr_start     : one-hot one-cycle write start to bank 0/1
//   wr_num_row   : row count of the bank being written
//   wr_done_i    : per-bank write-done level
//   rd_start     : one-hot one-cycle read start to bank 0/1
//   rd_num_row   : row count of the bank being read
//   rd_done_i    : per-bank read-complete pulse
//   busy         : some bank holds or is handling a tile
//   cmd_err      : one-cycle pulse, an out-of-range command was dropped
//   tiles_done   : completed-tile counter, wraps
module input_buf_sched
  import input_buf_pkg::*;
#(
  parameter int SYS_ROW    = DEF_SYS_ROW,
  parameter int SYS_COL    = DEF_SYS_COL,
  parameter int DATA_WIDTH = 16,
  parameter int ACCUM_SIZE = DEF_ACCUM_SIZE,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_num_row,
  output logic [1:0]            wr_start,
  output logic [DATA_WIDTH-1:0] wr_num_row,
  input  logic [1:0]            wr_done_i,
  output logic [1:0]            rd_start,
  output logic [DATA_WIDTH-1:0] rd_num_row,
  input  logic [1:0]            rd_done_i,
  output logic                  busy,
  output logic                  cmd_err,
  output logic [CNT_WIDTH-1:0]  tiles_done
);

  localparam int                    ACCUM_ROW_P = ACCUM_SIZE / SYS_COL;
  localparam logic [DATA_WIDTH-1:0] MAX_NUM_ROW = DATA_WIDTH'(ACCUM_ROW_P);
  // A degenerate array geometry has no legal tile size at all.
  localparam bit                    GEOMETRY_OK = (SYS_ROW > 0) && (ACCUM_ROW_P > 0);

  bank_state_t           bank_state [NUM_BANKS];
  logic [DATA_WIDTH-1:0] bank_nrow  [NUM_BANKS];
  logic [NUM_BANKS-1:0]  bank_load;
  logic [NUM_BANKS-1:0]  bank_rd_issue;
  logic [NUM_BANKS-1:0]  bank_drain_done;

  logic                  wr_ptr_reg;
  logic                  rd_ptr_reg;
  logic                  run_reg;
  logic                  any_loading;
  logic                  any_draining;
  logic                  any_busy;
  logic                  accept;
  logic                  cmd_legal;
  logic                  rd_issue;
  logic                  drain_done;

  logic [1:0]            wr_start_reg;
  logic [1:0]            rd_start_reg;
  logic [DATA_WIDTH-1:0] wr_num_row_reg;
  logic [DATA_WIDTH-1:0] rd_num_row_reg;
  logic                  cmd_err_reg;
  logic [CNT_WIDTH-1:0]  tiles_done_reg;

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    assign bank_load[gi]     = accept && cmd_legal && (wr_ptr_reg == 1'(gi));
    assign bank_rd_issue[gi] = rd_issue && (rd_ptr_reg == 1'(gi));

    input_buf_bank_fsm #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_bank (
      .clk          (clk),
      .rstn         (rstn),
      .load         (bank_load[gi]),
      .load_num_row (cmd_num_row),
      .wr_done      (wr_done_i[gi]),
      .rd_issue     (bank_rd_issue[gi]),
      .rd_done      (rd_done_i[gi]),
      .state        (bank_state[gi]),
      .nrow         (bank_nrow[gi]),
      .drain_done   (bank_drain_done[gi])
    );
  end

  always_comb begin
    any_loading  = 1'b0;
    any_draining = 1'b0;
    any_busy     = 1'b0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (bank_state[i] == LOADING)  any_loading  = 1'b1;
      if (bank_state[i] == DRAINING) any_draining = 1'b1;
      if (bank_state[i] != EMPTY)    any_busy     = 1'b1;
    end
  end

  // Ready depends on registered state only, so a bank freed by rd_done
  // becomes acceptable one cycle later. run_reg keeps ready low while in
  // reset. Only one load is in flight at a time.
  assign cmd_ready  = run_reg && (bank_state[wr_ptr_reg] == EMPTY) && !any_loading;
  assign accept     = cmd_valid && cmd_ready;
  assign cmd_legal  = GEOMETRY_OK && (cmd_num_row != '0) && (cmd_num_row <= MAX_NUM_ROW);

  // Reads go strictly in pointer order; a FULL bank that is not next in
  // line waits even if the other bank is empty.
  assign rd_issue   = (bank_state[rd_ptr_reg] == FULL) && !any_draining;
  assign drain_done = |bank_drain_done;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_reg        <= 1'b0;
      wr_ptr_reg     <= 1'b0;
      rd_ptr_reg     <= 1'b0;
      wr_start_reg   <= '0;
      rd_start_reg   <= '0;
      wr_num_row_reg <= '0;
      rd_num_row_reg <= '0;
      cmd_err_reg    <= 1'b0;
      tiles_done_reg <= '0;
    end else begin
      run_reg      <= 1'b1;
      wr_start_reg <= '0;
      rd_start_reg <= '0;
      cmd_err_reg  <= accept && !cmd_legal;

      if (accept && cmd_legal) begin
        wr_start_reg   <= bank_onehot(wr_ptr_reg);
        wr_num_row_reg <= cmd_num_row;
        wr_ptr_reg     <= !wr_ptr_reg;
      end

      if (rd_issue) begin
        rd_start_reg   <= bank_onehot(rd_ptr_reg);
        rd_num_row_reg <= bank_nrow[rd_ptr_reg];
      end

      if (drain_done) begin
        rd_ptr_reg     <= !rd_ptr_reg;
        tiles_done_reg <= tiles_done_reg + 1'b1;
      end
    end
  end

  assign wr_start   = wr_start_reg;
  assign rd_start   = rd_start_reg;
  assign wr_num_row = wr_num_row_reg;
  assign rd_num_row = rd_num_row_reg;
  assign cmd_err    = cmd_err_reg;
  assign tiles_done = tiles_done_reg;
  assign busy       = any_busy;

endmodule

// File: tb/tb_input_buf_sched.sv
module tb_input_buf_sched;
  import input_buf_pkg::*;

  localparam int DW     = 16;
  localparam int CW     = 4;
  localparam int WR_LAT = 9;
  localparam int RD_LAT = 5;

  typedef struct {
    int bank;
    int nrow;
    int due;
  } exp_t;

  typedef struct {
    int num_row;
    int exp_err;
  } vec_t;

  logic          clk;
  logic          rstn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [DW-1:0] cmd_num_row;
  logic [1:0]    wr_start;
  logic [DW-1:0] wr_num_row;
  logic [1:0]    wr_done_i;
  logic [1:0]    rd_start;
  logic [DW-1:0] rd_num_row;
  logic [1:0]    rd_done_i;
  logic [1:0]    rd_done_auto;
  logic [1:0]    rd_done_man;
  logic          busy;
  logic          cmd_err;
  logic [CW-1:0] tiles_done;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   exp_wr_ptr = 0;
  int   n_legal = 0;
  bit   rd_hold = 1'b0;
  exp_t wq[$];
  exp_t rq[$];

  assign rd_done_i = rd_done_auto | rd_done_man;

  input_buf_sched #(
    .SYS_ROW   (16),
    .SYS_COL   (16),
    .DATA_WIDTH(DW),
    .ACCUM_SIZE(4096),
    .CNT_WIDTH (CW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_num_row(cmd_num_row),
    .wr_start   (wr_start),
    .wr_num_row (wr_num_row),
    .wr_done_i  (wr_done_i),
    .rd_start   (rd_start),
    .rd_num_row (rd_num_row),
    .rd_done_i  (rd_done_i),
    .busy       (busy),
    .cmd_err    (cmd_err),
    .tiles_done (tiles_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bank-controller and array-side responders.
  initial begin
    int wcnt[2];
    int rcnt[2];
    wr_done_i    = '0;
    rd_done_auto = '0;
    for (int b = 0; b < 2; b++) begin
      wcnt[b] = 0;
      rcnt[b] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      rd_done_auto = '0;
      if (!rstn) begin
        wr_done_i = '0;
        for (int b = 0; b < 2; b++) begin
          wcnt[b] = 0;
          rcnt[b] = 0;
        end
      end else begin
        for (int b = 0; b < 2; b++) begin
          if (wr_start[b]) begin
            wr_done_i[b] = 1'b0;
            wcnt[b] = WR_LAT;
          end else if (wcnt[b] > 0) begin
            wcnt[b]--;
            if (wcnt[b] == 0) wr_done_i[b] = 1'b1;
          end
          if (rd_start[b]) begin
            rcnt[b] = RD_LAT;
          end else if (rcnt[b] > 1) begin
            rcnt[b]--;
          end else if (rcnt[b] == 1 && !rd_hold) begin
            rcnt[b] = 0;
            rd_done_auto[b] = 1'b1;
          end
        end
      end
    end
  end

  // Scoreboard monitor: pops expected write/read starts, tracks completions.
  initial begin
    exp_t e;
    int   exp_tiles;
    int   pend_inc;
    int   drain_bank;
    exp_tiles  = 0;
    pend_inc   = 0;
    drain_bank = -1;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        wq.delete();
        rq.delete();
        exp_tiles  = 0;
        pend_inc   = 0;
        drain_bank = -1;
        chk("rst_wr_start", int'(wr_start), 0);
        chk("rst_rd_start", int'(rd_start), 0);
        chk("rst_cmd_ready", int'(cmd_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cmd_err", int'(cmd_err), 0);
        chk("rst_tiles_done", int'(tiles_done), 0);
        chk("rst_wr_num_row", int'(wr_num_row), 0);
        chk("rst_rd_num_row", int'(rd_num_row), 0);
      end else begin
        if (pend_inc != 0) begin
          exp_tiles = (exp_tiles + 1) % (1 << CW);
          pend_inc  = 0;
        end
        chk("tiles_done", int'(tiles_done), exp_tiles);

        if (wr_start != 2'b00) begin
          if (wq.size() == 0) begin
            chk("wr_start_unexpected", int'(wr_start), 0);
          end else begin
            e = wq.pop_front();
            chk("wr_start_bank", int'(wr_start), 1 << e.bank);
            chk("wr_num_row", int'(wr_num_row), e.nrow);
            chk("wr_start_cycle", cyc, e.due);
          end
        end
        while (wq.size() > 0 && wq[0].due < cyc) begin
          e = wq.pop_front();
          chk("wr_start_missing", 0, 1 << e.bank);
        end

        if (rd_start != 2'b00) begin
          if (rq.size() == 0) begin
            chk("rd_start_unexpected", int'(rd_start), 0);
          end else begin
            e = rq.pop_front();
            chk("rd_start_bank", int'(rd_start), 1 << e.bank);
            chk("rd_num_row", int'(rd_num_row), e.nrow);
            drain_bank = e.bank;
          end
        end

        if (drain_bank >= 0 && rd_done_i[drain_bank]) begin
          pend_inc   = 1;
          drain_bank = -1;
        end
      end
    end
  end

  task automatic push_accept(input int nrow);
    exp_t e;
    e.bank = exp_wr_ptr;
    e.nrow = nrow;
    e.due  = cyc;
    wq.push_back(e);
    rq.push_back(e);
    exp_wr_ptr = 1 - exp_wr_ptr;
    n_legal++;
  endtask

  task automatic send_cmd(input int nrow, input int exp_err);
    bit got;
    got = 1'b0;
    @(posedge clk);
    #1;
    cmd_valid   = 1'b1;
    cmd_num_row = DW'(nrow);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (cmd_ready) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!got) begin
      chk("cmd_ready_timeout", 0, 1);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      if (exp_err == 0) push_accept(nrow);
      @(negedge clk);
      chk("cmd_err", int'(cmd_err), exp_err);
      if (exp_err != 0) begin
        @(negedge clk);
        chk("cmd_err_one_cycle", int'(cmd_err), 0);
      end
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_timeout", int'(ok), 1);
  endtask

  initial begin
    vec_t vecs[7];
    int   w;
    int   r;
    int   bpb;
    bit   got;

    vecs[0] = '{num_row: 0,             exp_err: 1};
    vecs[1] = '{num_row: ACCUM_ROW + 1, exp_err: 1};
    vecs[2] = '{num_row: ACCUM_ROW,     exp_err: 0};
    vecs[3] = '{num_row: 1,             exp_err: 0};
    vecs[4] = '{num_row: 300,           exp_err: 1};
    vecs[5] = '{num_row: 65535,         exp_err: 1};
    vecs[6] = '{num_row: 100,           exp_err: 0};

    rstn        = 1'b1;
    cmd_valid   = 1'b0;
    cmd_num_row = '0;
    rd_done_man = '0;
    #2 rstn = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rstn = 1'b1;

    // Single tile with exact latencies.
    send_cmd(8, 0);
    w = cyc;
    chk("single_busy_loading", int'(busy), 1);
    chk("single_ready_loading", int'(cmd_ready), 0);
    got = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (rd_start != 2'b00) begin
        got = 1'b1;
        chk("single_rd_latency", cyc - w, 11);
        chk("single_rd_start", int'(rd_start), 1);
        chk("single_rd_num_row", int'(rd_num_row), 8);
        break;
      end
    end
    chk("single_rd_timeout", int'(got), 1);
    wait_idle();
    chk("single_tiles", int'(tiles_done), 1);
    chk("single_busy_end", int'(busy), 0);

    // Ping-pong: two commands back to back.
    send_cmd(8, 0);
    send_cmd(12, 0);
    wait_idle();
    chk("pingpong_tiles", int'(tiles_done), n_legal % (1 << CW));

    // Backpressure: both banks occupied, third command waits for rd_done.
    rd_hold = 1'b1;
    bpb = exp_wr_ptr;
    send_cmd(5, 0);
    send_cmd(6, 0);
    @(posedge clk);
    #1;
    cmd_valid   = 1'b1;
    cmd_num_row = DW'(7);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("bp_ready_low", int'(cmd_ready), 0);
    end
    @(posedge clk);
    #1 rd_hold = 1'b0;
    r   = -100;
    got = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (rd_done_i[bpb]) r = cyc;
      if (cmd_ready) begin
        got = 1'b1;
        chk("bp_accept_cycle", cyc, r + 1);
        break;
      end
    end
    chk("bp_ready_timeout", int'(got), 1);
    if (got) begin
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      push_accept(7);
    end else begin
      cmd_valid = 1'b0;
    end
    wait_idle();
    chk("bp_tiles", int'(tiles_done), n_legal % (1 << CW));

    // Command legality table.
    for (int i = 0; i < 7; i++) begin
      send_cmd(vecs[i].num_row, vecs[i].exp_err);
    end
    wait_idle();
    chk("table_tiles", int'(tiles_done), n_legal % (1 << CW));

    // Reset while one bank drains and the other loads.
    rd_hold = 1'b1;
    send_cmd(20, 0);
    send_cmd(30, 0);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_wr_start", int'(wr_start), 0);
    chk("midrst_rd_start", int'(rd_start), 0);
    chk("midrst_cmd_ready", int'(cmd_ready), 0);
    chk("midrst_tiles", int'(tiles_done), 0);
    chk("midrst_wr_num_row", int'(wr_num_row), 0);
    chk("midrst_rd_num_row", int'(rd_num_row), 0);
    rd_hold = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rstn       = 1'b1;
    exp_wr_ptr = 0;
    n_legal    = 0;
    @(posedge clk);
    #1 rd_done_man = 2'b01;
    @(posedge clk);
    #1 rd_done_man = 2'b00;
    repeat (2) @(negedge clk);
    chk("stale_rd_done_tiles", int'(tiles_done), 0);
    chk("stale_rd_done_busy", int'(busy), 0);

    // Counter wrap on the 4-bit build: passes through 15, 0, 1.
    for (int i = 0; i < 17; i++) begin
      send_cmd(i + 1, 0);
      wait_idle();
      chk("wrap_tiles", int'(tiles_done), n_legal % (1 << CW));
    end

    repeat (3) @(negedge clk);
    chk("final_queue_wr", wq.size(), 0);
    chk("final_queue_rd", rq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
